// File: rtl/peripheral_timer_bank.sv
// -----------------------------------------------------------------------------
// peripheral_timer_bank
//   Memory-mapped peripheral on the CPU data bus. It holds N_TIMERS reload
//   timers that share one prescaler, each with a one-shot mode and an
//   interrupt flag that can be cleared by writing 1 to ISTAT. It also holds
//   the LED, 7-seg (digi) and switch registers and drives the CPU IRQ line.
//   Timer 0 is also reachable at the legacy offsets 0x00/0x04/0x08, so code
//   written for the single-timer block keeps working.
//
//   Offsets from BASE:
//     0x00 TH0   0x04 TL0   0x08 TCON0   (aliases of channel 0)
//     0x0C led   0x10 switch (RO)        0x14 digi
//     0x18 ISTAT (read irq_vec, write 1 to clear)
//     0x1C PRESC[15:0]
//     0x100 + 0x10*k : TH_k, +4 TL_k, +8 TCON_k
//   TCON bits: [0] EN, [1] IE, [2] FLAG, [3] ONESHOT
//
// Ports
//   clk      in   1         system clock
//   reset    in   1         asynchronous reset, active-high
//   rd       in   1         bus read strobe
//   wr       in   1         bus write strobe, sampled on posedge clk
//   addr     in   32        byte address
//   wdata    in   32        write data
//   rdata    out  32        read data, combinational (0 when idle/unmapped)
//   switch   in   SW_W      board switches
//   led      out  LED_W     LED register
//   digi     out  DIGI_W    7-seg register
//   irq_vec  out  N_TIMERS  per-timer interrupt flags
//   IRQ      out  1         OR of irq_vec
//
// Build option
//   SWITCH_DEBOUNCE_EN : when defined, the switch inputs go through a 2-flop
//   synchroniser and a per-bit debouncer (DEB_CYCLES stable cycles) before
//   being read at 0x10. When undefined, 0x10 returns the raw switch inputs.
// -----------------------------------------------------------------------------
module peripheral_timer_bank #(
  parameter int          N_TIMERS   = 2,
  parameter int          TW         = 32,
  parameter int          LED_W      = 8,
  parameter int          SW_W       = 8,
  parameter int          DIGI_W     = 12,
  parameter logic [31:0] BASE       = 32'h4000_0000,
  parameter logic [15:0] DEB_CYCLES = 16'd50000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rd,
  input  logic                wr,
  input  logic [31:0]         addr,
  input  logic [31:0]         wdata,
  output logic [31:0]         rdata,
  input  logic [SW_W-1:0]     switch,
  output logic [LED_W-1:0]    led,
  output logic [DIGI_W-1:0]   digi,
  output logic [N_TIMERS-1:0] irq_vec,
  output logic                IRQ
);

  if (N_TIMERS < 1 || N_TIMERS > 8) begin : g_bad_n_timers
    $error("peripheral_timer_bank: N_TIMERS must be 1..8");
  end
  if (TW < 8 || TW > 32) begin : g_bad_tw
    $error("peripheral_timer_bank: TW must be 8..32");
  end
  if (DEB_CYCLES == 16'd0) begin : g_bad_deb
    $error("peripheral_timer_bank: DEB_CYCLES must be nonzero");
  end

  typedef struct packed {
    logic oneshot;
    logic flag;
    logic ie;
    logic en;
  } tcon_t;

  logic [TW-1:0]       th_q   [N_TIMERS];
  logic [TW-1:0]       th_d   [N_TIMERS];
  logic [TW-1:0]       tl_q   [N_TIMERS];
  logic [TW-1:0]       tl_d   [N_TIMERS];
  tcon_t               tcon_q [N_TIMERS];
  tcon_t               tcon_d [N_TIMERS];
  logic [15:0]         presc_q, presc_d;
  logic [15:0]         pcnt_q, pcnt_d;
  logic [LED_W-1:0]    led_q, led_d;
  logic [DIGI_W-1:0]   digi_q, digi_d;

  logic [31:0]         off;
  logic                tick;
  logic [N_TIMERS-1:0] ovf;
  logic [N_TIMERS-1:0] hit_th, hit_tl, hit_tcon;
  logic                hit_led, hit_sw, hit_digi, hit_istat, hit_presc;
  logic [SW_W-1:0]     sw_val;

  // Address decode. Channel k lives at 0x100 + 0x10*k; channel 0 is also
  // aliased at the legacy offsets.
  always_comb begin
    off       = addr - BASE;
    hit_led   = (off == 32'h0C);
    hit_sw    = (off == 32'h10);
    hit_digi  = (off == 32'h14);
    hit_istat = (off == 32'h18);
    hit_presc = (off == 32'h1C);
    for (int k = 0; k < N_TIMERS; k++) begin
      hit_th[k]   = (off[31:8] == 24'h1) && (off[7:4] == 4'(k)) && (off[3:0] == 4'h0);
      hit_tl[k]   = (off[31:8] == 24'h1) && (off[7:4] == 4'(k)) && (off[3:0] == 4'h4);
      hit_tcon[k] = (off[31:8] == 24'h1) && (off[7:4] == 4'(k)) && (off[3:0] == 4'h8);
    end
    hit_th[0]   = hit_th[0]   || (off == 32'h00);
    hit_tl[0]   = hit_tl[0]   || (off == 32'h04);
    hit_tcon[0] = hit_tcon[0] || (off == 32'h08);
  end

  // Read path: the hits are mutually exclusive, so the order of the ifs
  // does not matter.
  always_comb begin
    // NOTE: every always_comb output gets a default first; a path that
    // leaves a variable unassigned would infer a latch.
    rdata = 32'h0;
    if (rd) begin
      if (hit_led)   rdata = 32'(led_q);
      if (hit_sw)    rdata = 32'(sw_val);
      if (hit_digi)  rdata = 32'(digi_q);
      if (hit_istat) rdata = 32'(irq_vec);
      if (hit_presc) rdata = 32'(presc_q);
      for (int k = 0; k < N_TIMERS; k++) begin
        if (hit_th[k])   rdata = 32'(th_q[k]);
        if (hit_tl[k])   rdata = 32'(tl_q[k]);
        if (hit_tcon[k]) rdata = 32'(tcon_q[k]);
      end
    end
  end

  // Next-state logic. Within each channel the order sets the priority:
  // timer update, then W1C clear, then bus writes, and finally the
  // overflow flag set, which must win over both kinds of clear.
  always_comb begin
    tick    = (pcnt_q == presc_q);
    pcnt_d  = tick ? 16'd0 : pcnt_q + 16'd1;
    presc_d = presc_q;
    led_d   = led_q;
    digi_d  = digi_q;
    if (wr && hit_presc) begin
      presc_d = wdata[15:0];
      pcnt_d  = 16'd0;
    end
    if (wr && hit_led)  led_d  = wdata[LED_W-1:0];
    if (wr && hit_digi) digi_d = wdata[DIGI_W-1:0];

    for (int k = 0; k < N_TIMERS; k++) begin
      th_d[k]   = th_q[k];
      tl_d[k]   = tl_q[k];
      tcon_d[k] = tcon_q[k];
      ovf[k]    = tick && tcon_q[k].en && (tl_q[k] == {TW{1'b1}});
      if (tick && tcon_q[k].en) begin
        if (ovf[k]) begin
          tl_d[k] = th_q[k];
          if (tcon_q[k].oneshot) tcon_d[k].en = 1'b0;
        end else begin
          tl_d[k] = tl_q[k] + 1'b1;
        end
      end
      if (wr && hit_istat && wdata[k]) tcon_d[k].flag = 1'b0;
      if (wr && hit_th[k])   th_d[k]   = wdata[TW-1:0];
      if (wr && hit_tl[k])   tl_d[k]   = wdata[TW-1:0];
      if (wr && hit_tcon[k]) tcon_d[k] = tcon_t'(wdata[3:0]);
      if (ovf[k] && tcon_q[k].ie) tcon_d[k].flag = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= 16'd0;
      pcnt_q  <= 16'd0;
      led_q   <= '0;
      digi_q  <= '0;
      // NOTE: the per-channel arrays are ordinary flops, not a RAM, so they
      // are reset like any other register.
      for (int k = 0; k < N_TIMERS; k++) begin
        th_q[k]   <= '0;
        tl_q[k]   <= '0;
        tcon_q[k] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      presc_q <= presc_d;
      pcnt_q  <= pcnt_d;
      led_q   <= led_d;
      digi_q  <= digi_d;
      for (int k = 0; k < N_TIMERS; k++) begin
        th_q[k]   <= th_d[k];
        tl_q[k]   <= tl_d[k];
        tcon_q[k] <= tcon_d[k];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < N_TIMERS; k++) irq_vec[k] = tcon_q[k].flag;
  end

  assign IRQ  = |irq_vec;
  assign led  = led_q;
  assign digi = digi_q;

`ifdef SWITCH_DEBOUNCE_EN
  logic [SW_W-1:0] sync1_q, sync2_q;
  logic [SW_W-1:0] deb_q, deb_d;
  logic [15:0]     deb_cnt_q [SW_W];
  logic [15:0]     deb_cnt_d [SW_W];

  // Each bit counts consecutive cycles on which the synchronised input
  // disagrees with the debounced value; any agreeing cycle restarts it.
  always_comb begin
    for (int i = 0; i < SW_W; i++) begin
      deb_d[i]     = deb_q[i];
      deb_cnt_d[i] = 16'd0;
      if (sync2_q[i] != deb_q[i]) begin
        if (deb_cnt_q[i] == DEB_CYCLES - 16'd1) deb_d[i] = sync2_q[i];
        else                                    deb_cnt_d[i] = deb_cnt_q[i] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      for (int i = 0; i < SW_W; i++) deb_cnt_q[i] <= 16'd0;
    end else begin
      sync1_q <= switch;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      for (int i = 0; i < SW_W; i++) deb_cnt_q[i] <= deb_cnt_d[i];
    end
  end

  assign sw_val = deb_q;
`else
  assign sw_val = switch;
`endif

endmodule

// File: tb/tb_peripheral_timer_bank.sv
module tb_peripheral_timer_bank;

  localparam logic [31:0] B = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic [7:0]  switch = 8'h0;
  logic [7:0]  led;
  logic [11:0] digi;
  logic [1:0]  irq_vec;
  logic        IRQ;

  int n_cmp = 0;
  int n_bad = 0;

  peripheral_timer_bank dut (
    .clk     (clk),
    .reset   (reset),
    .rd      (rd),
    .wr      (wr),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .switch  (switch),
    .led     (led),
    .digi    (digi),
    .irq_vec (irq_vec),
    .IRQ     (IRQ)
  );

  always #5 clk = ~clk;

  // All bus activity starts just after a falling edge: a write is taken at
  // the next rising edge and the task returns at the falling edge after it.
  task automatic wr_reg(input logic [31:0] off, input logic [31:0] d);
    addr  = B + off;
    wdata = d;
    wr    = 1'b1;
    @(negedge clk);
    wr    = 1'b0;
  endtask

  task automatic rd_reg(input logic [31:0] off, output logic [31:0] d);
    addr = B + off;
    rd   = 1'b1;
    #1;
    d    = rdata;
    rd   = 1'b0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    logic [31:0] v;
    cyc(2);
    n_cmp++; if (led !== 8'h0) begin n_bad++; $display("FAIL rst_led: got %h want 00", led); end
    n_cmp++; if (digi !== 12'h0) begin n_bad++; $display("FAIL rst_digi: got %h want 000", digi); end
    n_cmp++; if (irq_vec !== 2'b00 || IRQ !== 1'b0) begin n_bad++; $display("FAIL rst_irq: got %b/%b want 00/0", irq_vec, IRQ); end
    rd_reg(32'h100, v);
    n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL rst_th0: got %h want 0", v); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_regs;
    logic [31:0] v;
    switch = 8'h3C;
    rd_reg(32'h10, v);
    n_cmp++; if (v !== 32'h3C) begin n_bad++; $display("FAIL sw_read: got %h want 3c", v); end
    wr_reg(32'h10, 32'hFF);
    rd_reg(32'h10, v);
    n_cmp++; if (v !== 32'h3C) begin n_bad++; $display("FAIL sw_ro: got %h want 3c", v); end
    wr_reg(32'h0C, 32'hFFFF_FFA5);
    rd_reg(32'h0C, v);
    n_cmp++; if (v !== 32'hA5 || led !== 8'hA5) begin n_bad++; $display("FAIL led: got %h/%h want a5", v, led); end
    wr_reg(32'h14, 32'hFFFF_FFFF);
    rd_reg(32'h14, v);
    n_cmp++; if (v !== 32'hFFF || digi !== 12'hFFF) begin n_bad++; $display("FAIL digi: got %h/%h want fff", v, digi); end
    addr = B + 32'h0C; rd = 1'b0; #1;
    n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL rd_idle: got %h want 0", rdata); end
    wr_reg(32'h1C, 32'h0001_1234);
    rd_reg(32'h1C, v);
    n_cmp++; if (v !== 32'h1234) begin n_bad++; $display("FAIL presc: got %h want 1234", v); end
    wr_reg(32'h1C, 32'h0);
    wr_reg(32'h100, 32'hCAFE_F00D);
    rd_reg(32'h00, v);
    n_cmp++; if (v !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL alias_th0: got %h want cafef00d", v); end
    wr_reg(32'h120, 32'h1234_5678);
    rd_reg(32'h110, v);
    n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL unmapped_wr: got %h want 0", v); end
    rd_reg(32'h120, v);
    n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL unmapped_120: got %h want 0", v); end
    rd_reg(32'h10C, v);
    n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL unmapped_10c: got %h want 0", v); end
    rd_reg(32'h20, v);
    n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL unmapped_20: got %h want 0", v); end
    @(negedge clk);
  endtask

  task automatic test_overflow;
    logic [31:0] v;
    wr_reg(32'h00, 32'hFFFF_FFFC);
    wr_reg(32'h04, 32'hFFFF_FFFE);
    wr_reg(32'h08, 32'h3);
    rd_reg(32'h04, v);
    n_cmp++; if (v !== 32'hFFFF_FFFE || IRQ !== 1'b0) begin n_bad++; $display("FAIL ovf_t0: got %h/%b want fffffffe/0", v, IRQ); end
    cyc(1);
    rd_reg(32'h04, v);
    n_cmp++; if (v !== 32'hFFFF_FFFF || IRQ !== 1'b0) begin n_bad++; $display("FAIL ovf_t1: got %h/%b want ffffffff/0", v, IRQ); end
    cyc(1);
    rd_reg(32'h04, v);
    n_cmp++; if (v !== 32'hFFFF_FFFC || IRQ !== 1'b1) begin n_bad++; $display("FAIL ovf_t2: got %h/%b want fffffffc/1", v, IRQ); end
    rd_reg(32'h18, v);
    n_cmp++; if (v !== 32'h1) begin n_bad++; $display("FAIL ovf_istat: got %h want 1", v); end
    rd_reg(32'h108, v);
    n_cmp++; if (v !== 32'h7) begin n_bad++; $display("FAIL ovf_tcon0: got %h want 7", v); end
    wr_reg(32'h08, 32'h0);
    rd_reg(32'h104, v);
    n_cmp++; if (v !== 32'hFFFF_FFFD || IRQ !== 1'b0) begin n_bad++; $display("FAIL ovf_stop: got %h/%b want fffffffd/0", v, IRQ); end
    @(negedge clk);
  endtask

  task automatic test_prescaler;
    logic [31:0] v;
    wr_reg(32'h1C, 32'h3);
    wr_reg(32'h114, 32'h0);
    wr_reg(32'h118, 32'h1);
    wr_reg(32'h1C, 32'h3);
    rd_reg(32'h114, v);
    n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL presc_c0: got %h want 0", v); end
    cyc(3);
    rd_reg(32'h114, v);
    n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL presc_c3: got %h want 0", v); end
    cyc(1);
    rd_reg(32'h114, v);
    n_cmp++; if (v !== 32'h1) begin n_bad++; $display("FAIL presc_c4: got %h want 1", v); end
    cyc(3);
    rd_reg(32'h114, v);
    n_cmp++; if (v !== 32'h1) begin n_bad++; $display("FAIL presc_c7: got %h want 1", v); end
    cyc(1);
    rd_reg(32'h114, v);
    n_cmp++; if (v !== 32'h2) begin n_bad++; $display("FAIL presc_c8: got %h want 2", v); end
    @(negedge clk);
    wr_reg(32'h118, 32'h0);
  endtask

  task automatic test_oneshot;
    logic [31:0] v;
    wr_reg(32'h1C, 32'h0);
    wr_reg(32'h110, 32'h1234_5678);
    wr_reg(32'h114, 32'hFFFF_FFFF);
    wr_reg(32'h118, 32'hB);
    rd_reg(32'h114, v);
    n_cmp++; if (v !== 32'hFFFF_FFFF || IRQ !== 1'b0) begin n_bad++; $display("FAIL os_pre: got %h/%b want ffffffff/0", v, IRQ); end
    cyc(1);
    rd_reg(32'h114, v);
    n_cmp++; if (v !== 32'h1234_5678) begin n_bad++; $display("FAIL os_reload: got %h want 12345678", v); end
    rd_reg(32'h118, v);
    n_cmp++; if (v !== 32'hE) begin n_bad++; $display("FAIL os_tcon: got %h want e", v); end
    n_cmp++; if (irq_vec !== 2'b10 || IRQ !== 1'b1) begin n_bad++; $display("FAIL os_irq: got %b/%b want 10/1", irq_vec, IRQ); end
    cyc(2);
    rd_reg(32'h114, v);
    n_cmp++; if (v !== 32'h1234_5678) begin n_bad++; $display("FAIL os_hold: got %h want 12345678", v); end
    wr_reg(32'h18, 32'h1);
    n_cmp++; if (irq_vec !== 2'b10) begin n_bad++; $display("FAIL w1c_other: got %b want 10", irq_vec); end
    wr_reg(32'h18, 32'h2);
    rd_reg(32'h118, v);
    n_cmp++; if (v !== 32'hA || irq_vec !== 2'b00) begin n_bad++; $display("FAIL w1c: got %h/%b want a/00", v, irq_vec); end
    @(negedge clk);
  endtask

  task automatic test_simultaneous;
    logic [31:0] v;
    wr_reg(32'h114, 32'hFFFF_FFFE);
    wr_reg(32'h118, 32'h3);
    cyc(1);
    wr_reg(32'h18, 32'h2);
    rd_reg(32'h114, v);
    n_cmp++; if (irq_vec !== 2'b10 || v !== 32'h1234_5678) begin n_bad++; $display("FAIL ovf_vs_w1c: got %b/%h want 10/12345678", irq_vec, v); end
    @(negedge clk);
    wr_reg(32'h18, 32'h2);
    n_cmp++; if (irq_vec !== 2'b00) begin n_bad++; $display("FAIL w1c_again: got %b want 00", irq_vec); end
    wr_reg(32'h114, 32'hFFFF_FFFE);
    rd_reg(32'h114, v);
    n_cmp++; if (v !== 32'hFFFF_FFFE) begin n_bad++; $display("FAIL tl_wr_beats_inc: got %h want fffffffe", v); end
    cyc(1);
    rd_reg(32'h114, v);
    n_cmp++; if (v !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL tl_pre_ovf: got %h want ffffffff", v); end
    wr_reg(32'h114, 32'h55);
    rd_reg(32'h114, v);
    n_cmp++; if (v !== 32'h55 || irq_vec !== 2'b10) begin n_bad++; $display("FAIL tl_wr_ovf: got %h/%b want 55/10", v, irq_vec); end
    @(negedge clk);
    wr_reg(32'h118, 32'h0);
    n_cmp++; if (IRQ !== 1'b0) begin n_bad++; $display("FAIL tcon_clr: got %b want 0", IRQ); end
    wr_reg(32'h114, 32'hFFFF_FFFF);
    wr_reg(32'h118, 32'h3);
    wr_reg(32'h118, 32'h1);
    rd_reg(32'h118, v);
    n_cmp++; if (v !== 32'h5 || IRQ !== 1'b1) begin n_bad++; $display("FAIL ovf_vs_tcon: got %h/%b want 5/1", v, IRQ); end
    rd_reg(32'h114, v);
    n_cmp++; if (v !== 32'h1234_5678) begin n_bad++; $display("FAIL ovf_vs_tcon_tl: got %h want 12345678", v); end
    @(negedge clk);
    wr_reg(32'h118, 32'h0);
  endtask

  task automatic test_reset_mid;
    logic [31:0] v;
    wr_reg(32'h00, 32'h0);
    wr_reg(32'h04, 32'hFFFF_FFFF);
    wr_reg(32'h0C, 32'h5A);
    wr_reg(32'h08, 32'h3);
    cyc(1);
    n_cmp++; if (IRQ !== 1'b1 || led !== 8'h5A) begin n_bad++; $display("FAIL pre_reset: got %b/%h want 1/5a", IRQ, led); end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++; if (led !== 8'h0 || digi !== 12'h0) begin n_bad++; $display("FAIL midrst_regs: got %h/%h want 00/000", led, digi); end
    n_cmp++; if (irq_vec !== 2'b00 || IRQ !== 1'b0) begin n_bad++; $display("FAIL midrst_irq: got %b/%b want 00/0", irq_vec, IRQ); end
    rd_reg(32'h100, v);
    n_cmp++; if (v !== 32'h0) begin n_bad++; $display("FAIL midrst_th0: got %h want 0", v); end
    @(negedge clk);
    reset = 1'b0;
    cyc(2);
    rd_reg(32'h04, v);
    n_cmp++; if (v !== 32'h0 || IRQ !== 1'b0) begin n_bad++; $display("FAIL postrst_idle: got %h/%b want 0/0", v, IRQ); end
  endtask

  initial begin
    test_reset;
    test_regs;
    test_overflow;
    test_prescaler;
    test_oneshot;
    test_simultaneous;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
